// File: rtl/rsa_exp_ctrl.sv
// Square-and-multiply sequencer driving one shared Montgomery multiplier; one MMM op is WIDTH+3 cycles.
// Latency (3+WIDTH+popcount(E))*(WIDTH+3)+1 cycles from start; start is ignored while busy or during done.
module rsa_exp_ctrl #(
  parameter int WIDTH = 10,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] msg,
  input  logic [WIDTH-1:0] exp_e,
  input  logic [WIDTH-1:0] mod_m,
  input  logic [WIDTH-1:0] r2_mod,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             mmm_rst,
  output logic             mmm_ld_a,
  output logic             mmm_en,
  output logic             mmm_ld_r,
  output logic             mmm_lock,
  output logic [WIDTH-1:0] mmm_a,
  output logic [WIDTH-1:0] mmm_b,
  input  logic [WIDTH-1:0] mmm_r
);

  typedef enum logic [2:0] {
    S_IDLE, S_PRE_X, S_PRE_ONE, S_SQR, S_MUL, S_POST, S_FIX
  } state_t;

  typedef enum logic [1:0] {
    P_LOAD, P_RUN, P_CAPT, P_WB
  } phase_t;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  localparam logic [CNT_W-1:0] TOP = CNT_W'(WIDTH - 1);

  state_t           state;
  phase_t           phase;
  logic [CNT_W-1:0] cyc_cnt;
  logic [CNT_W-1:0] bit_idx;
  logic [WIDTH-1:0] exp_q;
  logic [WIDTH-1:0] r2_q;
  logic [WIDTH-1:0] xm;
  logic [WIDTH-1:0] t_q;

  state_t           nxt_state;
  logic [WIDTH-1:0] nxt_a;
  logic [WIDTH-1:0] nxt_b;
  logic [CNT_W-1:0] nxt_bit;
  logic             last_bit;

  assign last_bit = (bit_idx == '0);

  // The running accumulator is never stored separately: it is the product just
  // returned, fed straight back into the operand registers for the next op.
  always_comb begin
    nxt_state = S_FIX;
    nxt_a     = mmm_r;
    nxt_b     = mmm_r;
    nxt_bit   = bit_idx;
    case (state)
      S_PRE_X: begin
        nxt_state = S_PRE_ONE;
        nxt_a     = ONE;
        nxt_b     = r2_q;
      end
      S_PRE_ONE: begin
        nxt_state = S_SQR;
        nxt_bit   = TOP;
      end
      S_SQR: begin
        if (exp_q[bit_idx]) begin
          nxt_state = S_MUL;
          nxt_b     = xm;
        end else if (last_bit) begin
          nxt_state = S_POST;
          nxt_b     = ONE;
        end else begin
          nxt_state = S_SQR;
          nxt_bit   = bit_idx - CNT_W'(1);
        end
      end
      S_MUL: begin
        if (last_bit) begin
          nxt_state = S_POST;
          nxt_b     = ONE;
        end else begin
          nxt_state = S_SQR;
          nxt_bit   = bit_idx - CNT_W'(1);
        end
      end
      default: nxt_state = S_FIX;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      phase    <= P_LOAD;
      cyc_cnt  <= '0;
      bit_idx  <= '0;
      exp_q    <= '0;
      r2_q     <= '0;
      xm       <= '0;
      t_q      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      mmm_rst  <= 1'b0;
      mmm_ld_a <= 1'b0;
      mmm_en   <= 1'b0;
      mmm_ld_r <= 1'b0;
      mmm_lock <= 1'b1;
      mmm_a    <= '0;
      mmm_b    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          // A start coinciding with the done pulse belongs to the finished run.
          if (start && !done) begin
            exp_q    <= exp_e;
            r2_q     <= r2_mod;
            mmm_a    <= msg;
            mmm_b    <= r2_mod;
            busy     <= 1'b1;
            state    <= S_PRE_X;
            phase    <= P_LOAD;
            mmm_rst  <= 1'b1;
            mmm_ld_a <= 1'b1;
            mmm_en   <= 1'b1;
            mmm_lock <= 1'b0;
          end
        end
        S_FIX: begin
          result <= (t_q >= mod_m) ? t_q - mod_m : t_q;
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= S_IDLE;
        end
        default: begin
          case (phase)
            P_LOAD: begin
              mmm_rst  <= 1'b0;
              mmm_ld_a <= 1'b0;
              cyc_cnt  <= TOP;
              phase    <= P_RUN;
            end
            P_RUN: begin
              if (cyc_cnt == '0) begin
                mmm_ld_r <= 1'b1;
                phase    <= P_CAPT;
              end else begin
                cyc_cnt <= cyc_cnt - CNT_W'(1);
              end
            end
            P_CAPT: begin
              mmm_ld_r <= 1'b0;
              mmm_en   <= 1'b0;
              phase    <= P_WB;
            end
            P_WB: begin
              if (state == S_PRE_X) xm <= mmm_r;
              if (state == S_POST) t_q <= mmm_r;
              state   <= nxt_state;
              bit_idx <= nxt_bit;
              if (nxt_state == S_FIX) begin
                mmm_lock <= 1'b1;
              end else begin
                mmm_a    <= nxt_a;
                mmm_b    <= nxt_b;
                phase    <= P_LOAD;
                mmm_rst  <= 1'b1;
                mmm_ld_a <= 1'b1;
                mmm_en   <= 1'b1;
              end
            end
            default: phase <= P_LOAD;
          endcase
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rsa_exp_ctrl.sv
// Bench for rsa_exp_ctrl with a bit-serial Montgomery multiplier model and a plain modular-power reference.
module tb_rsa_exp_ctrl;
  localparam int W = 10;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] msg = '0, exp_e = '0, mod_m = W'(187), r2_mod = '0;
  logic         busy, done;
  logic [W-1:0] result;
  logic         mmm_rst, mmm_ld_a, mmm_en, mmm_ld_r, mmm_lock;
  logic [W-1:0] mmm_a, mmm_b;
  logic [W-1:0] mmm_r;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  rsa_exp_ctrl #(.WIDTH(W), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .msg(msg), .exp_e(exp_e), .mod_m(mod_m),
    .r2_mod(r2_mod), .busy(busy), .done(done), .result(result), .mmm_rst(mmm_rst),
    .mmm_ld_a(mmm_ld_a), .mmm_en(mmm_en), .mmm_ld_r(mmm_ld_r), .mmm_lock(mmm_lock),
    .mmm_a(mmm_a), .mmm_b(mmm_b), .mmm_r(mmm_r)
  );

  // Bit-serial Montgomery multiplier: A consumed LSB first, one bit per enabled cycle.
  logic [W-1:0] mm_ash, mm_aref, mm_bref;
  logic [W+1:0] mm_acc;
  int ldr_cnt = 0;
  int opnd_err = 0;
  always @(posedge clk) begin
    logic [W+1:0] s;
    if (rst) begin
      mm_acc <= '0;
      mm_ash <= '0;
      mmm_r  <= '0;
    end else begin
      if (mmm_ld_r && !mmm_lock) begin
        mmm_r <= mm_acc[W-1:0];
        ldr_cnt++;
      end
      if (mmm_rst) begin
        mm_acc <= '0;
      end else if (mmm_en && !mmm_ld_r) begin
        s = mm_acc + (mm_ash[0] ? {2'b00, mmm_b} : '0);
        if (s[0]) s = s + {2'b00, mod_m};
        mm_acc <= s >> 1;
        mm_ash <= mm_ash >> 1;
      end
      if (mmm_ld_a) begin
        mm_ash  <= mmm_a;
        mm_aref <= mmm_a;
        mm_bref <= mmm_b;
      end else if (mmm_en && (mmm_a !== mm_aref || mmm_b !== mm_bref)) begin
        opnd_err++;
      end
    end
  end

  function automatic logic [W-1:0] ref_pow(input int unsigned x, input int unsigned e,
                                           input int unsigned m);
    int unsigned r;
    r = 1 % m;
    for (int k = 0; k < e; k++) r = (r * x) % m;
    return W'(r);
  endfunction

  function automatic int ref_lat(input int unsigned e);
    return (3 + W + $countones(e)) * (W + 3) + 1;
  endfunction

  // Drives one run; p1/p2 re-pulse start that many cycles after acceptance (0 = none).
  task automatic do_run(input logic [W-1:0] x, input logic [W-1:0] e, input logic [W-1:0] m,
                        input logic [W-1:0] r2, input int p1, input int p2,
                        output int lat, output logic [W-1:0] res, output int nops,
                        output int oerr, output logic bsy);
    int n, base_ops, base_err;
    @(posedge clk); #1;
    mod_m = m; msg = x; exp_e = e; r2_mod = r2; start = 1'b1;
    base_ops = ldr_cnt; base_err = opnd_err;
    @(posedge clk); #1;
    start = 1'b0;
    msg = W'($urandom); exp_e = W'($urandom); r2_mod = W'($urandom);
    lat = -1; n = 0;
    while (n < 400) begin
      @(posedge clk); #1;
      n++;
      if (done) begin
        lat = n;
        break;
      end
      start = (n == p1 || n == p2);
    end
    start = 1'b0;
    res = result; bsy = busy;
    nops = ldr_cnt - base_ops; oerr = opnd_err - base_err;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== '0) begin
      miscompares++;
      $display("FAIL reset_status busy=%b done=%b result=%0d want 0/0/0", busy, done, result);
    end
    vectors++;
    if ({mmm_rst, mmm_ld_a, mmm_en, mmm_ld_r, mmm_lock} !== 5'b00001) begin
      miscompares++;
      $display("FAIL reset_strobes got=%b want=00001",
               {mmm_rst, mmm_ld_a, mmm_en, mmm_ld_r, mmm_lock});
    end
    vectors++;
    if (mmm_a !== '0 || mmm_b !== '0) begin
      miscompares++;
      $display("FAIL reset_operands a=%0d b=%0d want 0/0", mmm_a, mmm_b);
    end
    rst = 1'b0;
  endtask

  task automatic check_run(input string name, input logic [W-1:0] x, input logic [W-1:0] e,
                           input logic [W-1:0] m, input int p1, input int p2);
    int lat, nops, oerr;
    logic [W-1:0] res, want;
    logic bsy;
    do_run(x, e, m, W'((64'd1 << (2 * W)) % m), p1, p2, lat, res, nops, oerr, bsy);
    want = ref_pow(x, e, m);
    vectors++;
    if (res !== want) begin
      miscompares++;
      $display("FAIL %s_result x=%0d e=%0d m=%0d got=%0d want=%0d", name, x, e, m, res, want);
    end
    vectors++;
    if (lat != ref_lat(e)) begin
      miscompares++;
      $display("FAIL %s_latency e=%0d got=%0d want=%0d", name, e, lat, ref_lat(e));
    end
    vectors++;
    if (nops != 3 + W + $countones(e) || oerr != 0) begin
      miscompares++;
      $display("FAIL %s_ops got=%0d opnd_err=%0d want=%0d/0", name, nops, oerr,
               3 + W + $countones(e));
    end
    vectors++;
    if (bsy !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_busy_at_done got=%b want=0", name, bsy);
    end
  endtask

  task automatic test_directed;
    check_run("dir_5_3", W'(5), W'(3), W'(187), 0, 0);
    check_run("dir_2_7", W'(2), W'(7), W'(187), 0, 0);
    check_run("dir_e0", W'(100), W'(0), W'(187), 0, 0);
    check_run("dir_neg1", W'(186), W'(1023), W'(187), 0, 0);
  endtask

  task automatic test_random;
    logic [W-1:0] m, x, e;
    for (int i = 0; i < 12; i++) begin
      m = W'($urandom_range(1, 127) * 2 + 1);
      x = W'($urandom_range(0, int'(m) - 1));
      e = W'($urandom_range(0, 1023));
      check_run("rand", x, e, m, 0, 0);
    end
  endtask

  task automatic test_restart_ignored;
    check_run("restart", W'(2), W'(7), W'(187), 5, 100);
  endtask

  task automatic test_reset_midrun;
    @(posedge clk); #1;
    mod_m = W'(187); msg = W'(5); exp_e = W'(3); r2_mod = W'(67); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (49) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== '0 || mmm_lock !== 1'b1 || mmm_en !== 1'b0) begin
      miscompares++;
      $display("FAIL midrun_reset busy=%b done=%b result=%0d lock=%b en=%b want 0/0/0/1/0",
               busy, done, result, mmm_lock, mmm_en);
    end
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL midrun_no_done done=%b busy=%b want 0/0", done, busy);
    end
    check_run("after_reset", W'(5), W'(3), W'(187), 0, 0);
  endtask

  task automatic test_back_to_back;
    int lat, nops, oerr;
    logic [W-1:0] res;
    logic bsy;
    do_run(W'(3), W'(5), W'(187), W'(67), 0, 0, lat, res, nops, oerr, bsy);
    vectors++;
    if (res !== ref_pow(3, 5, 187)) begin
      miscompares++;
      $display("FAIL b2b_first got=%0d want=%0d", res, ref_pow(3, 5, 187));
    end
    start = 1'b1;
    msg = W'(9); exp_e = W'(2);
    @(posedge clk); #1;
    start = 1'b0;
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || mmm_lock !== 1'b1 || result !== res) begin
      miscompares++;
      $display("FAIL b2b_done_cycle_start busy=%b done=%b lock=%b result=%0d want 0/0/1/%0d",
               busy, done, mmm_lock, result, res);
    end
    repeat (4) @(posedge clk);
    #1;
    vectors++;
    if (result !== res || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_hold result=%0d busy=%b want %0d/0", result, busy, res);
    end
    check_run("b2b_second", W'(9), W'(2), W'(187), 0, 0);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_restart_ignored();
    test_reset_midrun();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
